// File: rtl/mem_dump_ctrl_pkg.sv
// Shared definitions for the memory dump controller: memory addressing codes,
// FSM state encoding and word/byte geometry.
package mem_dump_ctrl_pkg;

    // Addressing codes understood by the data memory read port.
    localparam logic [1:0] ADDR_WORD = 2'b00;
    localparam logic [1:0] ADDR_HALF = 2'b01;
    localparam logic [1:0] ADDR_BYTE = 2'b11;

    // Geometry of the default 64-byte data memory.
    localparam int unsigned BYTES_PER_WORD    = 4;
    localparam int unsigned N_ADDRESS_DEFAULT = 64;
    localparam int unsigned N_WORDS           = N_ADDRESS_DEFAULT / BYTES_PER_WORD;

    // Dump FSM, 2-bit binary encoding.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRead = 2'b01,
        StSend = 2'b10,
        StDone = 2'b11
    } dump_state_e;

    // Number of whole words in a memory of n_address bytes.
    function automatic int unsigned words_in(input int unsigned n_address);
        return n_address / BYTES_PER_WORD;
    endfunction

endpackage

// File: rtl/mem_dump_ctrl_word_byte_serializer.sv
// Loads one memory word and hands it out byte by byte, LSB first, over a
// valid/ready handshake. Flags the cycle in which the final byte is accepted.
module mem_dump_ctrl_word_byte_serializer
    import mem_dump_ctrl_pkg::*;
#(
    parameter int unsigned NB_DATA_BUS = 32,
    parameter int unsigned NB_BYTE     = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_load,
    input  logic [NB_DATA_BUS-1:0] i_word,
    output logic [NB_BYTE-1:0]     o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_last_accept
);

    localparam int unsigned N_BYTES = BYTES_PER_WORD;
    localparam int unsigned NB_IDX  = $clog2(N_BYTES);
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_BYTES - 1);

    logic [NB_DATA_BUS-1:0] word_q;
    logic [NB_IDX-1:0]      idx_q;
    logic [NB_BYTE-1:0]     data_q;
    logic                   valid_q;

    logic                   accept;
    logic [NB_IDX-1:0]      idx_inc;
    logic [NB_BYTE-1:0]     next_byte;

    assign accept        = valid_q & i_tx_ready;
    assign o_last_accept = accept & (idx_q == LAST_IDX);

    // Byte that follows the one currently on the bus; wraps harmlessly after the last.
    always_comb begin
        idx_inc   = idx_q + 1'b1;
        next_byte = word_q[NB_BYTE*idx_inc +: NB_BYTE];
    end

    // Word buffer, byte index and the registered TX handshake outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            word_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (i_load) begin
            word_q  <= i_word;
            idx_q   <= '0;
            data_q  <= i_word[NB_BYTE-1:0];
            valid_q <= 1'b1;
        end else if (accept) begin
            if (idx_q == LAST_IDX) begin
                // Word exhausted: drop valid and keep the last byte on the bus.
                idx_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                idx_q  <= idx_inc;
                data_q <= next_byte;
            end
        end
    end

    assign o_tx_data  = data_q;
    assign o_tx_valid = valid_q;

endmodule

// File: rtl/mem_dump_ctrl.sv
// Debug memory dump: walks the data memory word by word from address 0 and
// streams every word to the debug UART as 4 bytes, LSB first.
module mem_dump_ctrl
    import mem_dump_ctrl_pkg::*;
#(
    parameter int unsigned NB_DATA_BUS = 32,
    parameter int unsigned NB_BYTE     = 8,
    parameter int unsigned N_ADDRESS   = N_ADDRESS_DEFAULT,
    parameter int unsigned NB_ADDRESS  = $clog2(N_ADDRESS)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [NB_ADDRESS-1:0]  o_mem_r_addr,
    output logic                   o_mem_r_en,
    output logic [1:0]             o_mem_r_addressing,
    input  logic [NB_DATA_BUS-1:0] i_mem_r_data,
    output logic [NB_BYTE-1:0]     o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready
);

    localparam logic [NB_ADDRESS-1:0] LAST_ADDR = NB_ADDRESS'(N_ADDRESS - BYTES_PER_WORD);
    localparam logic [NB_ADDRESS-1:0] ADDR_STEP = NB_ADDRESS'(BYTES_PER_WORD);

    dump_state_e             state_q;
    logic [NB_ADDRESS-1:0]   addr_q;
    logic                    mem_r_en_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    load_word;
    logic                    last_accept;

    // The read data is valid at the posedge closing the READ cycle.
    assign load_word = (state_q == StRead);

    // Dump FSM with address counter and registered memory-side outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            mem_r_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_q    <= StRead;
                        addr_q     <= '0;
                        mem_r_en_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                StRead: begin
                    mem_r_en_q <= 1'b0;
                    state_q    <= StSend;
                end
                StSend: begin
                    if (last_accept) begin
                        if (addr_q == LAST_ADDR) begin
                            // Address is left at the last word; it only clears on the next start.
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q     <= addr_q + ADDR_STEP;
                            mem_r_en_q <= 1'b1;
                            state_q    <= StRead;
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    mem_dump_ctrl_word_byte_serializer #(
        .NB_DATA_BUS (NB_DATA_BUS),
        .NB_BYTE     (NB_BYTE)
    ) u_serializer (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_load        (load_word),
        .i_word        (i_mem_r_data),
        .o_tx_data     (o_tx_data),
        .o_tx_valid    (o_tx_valid),
        .i_tx_ready    (i_tx_ready),
        .o_last_accept (last_accept)
    );

    assign o_busy             = busy_q;
    assign o_done             = done_q;
    assign o_mem_r_addr       = addr_q;
    assign o_mem_r_en         = mem_r_en_q;
    assign o_mem_r_addressing = ADDR_WORD;

endmodule
